data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder side of the core's load/store port. Accepts one request at a time from the
//  RV32I datapath over a valid/ready handshake. Stores via byte enables, or reads with
//  LB/LH/LW/LBU/LHU extension. Returns data after a configurable number of wait states.
//  Sits beside Datapath under the top module; replaces the ideal zero-latency data memory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words in the storage array (power of two)
//  WAIT_STATES  2    extra cycles between request accept and response (0..15)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   core presents a request
//  req_ready  out  1   responder can accept a request this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSB-aligned (rs2 value)
//  req_func3  in   3   access size/sign: instruction func3 field
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   core consumes response this cycle
//  rsp_rdata  out  32  load data, extended; 0 for stores and errors
//  rsp_err    out  1   misaligned, out-of-range or illegal func3
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, req_ready=0 while asserted, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata/func3, counter=0,
//    then go to WAIT. If WAIT_STATES=0, go directly to RESP.
//    WAIT: counter increments each cycle. Leave for RESP when counter==WAIT_STATES-1.
//    RESP: rsp_valid=1; outputs held stable until rsp_ready=1, then IDLE next cycle.
//  - Latency: accept edge to rsp_valid high = WAIT_STATES+1 cycles.
//  - req_ready=0 outside IDLE. Requests presented then are ignored, not queued.
//  - Store/read commit: exactly once, on the clock edge that enters RESP; never on error.
//    Read data is registered on that same edge, so rsp_rdata is stable in RESP.
//  - Decode, word index = addr[2+$clog2(DEPTH_WORDS)-1:2], lane = addr[1:0]:
//    - func3 000 byte: SB writes lane byte; LB sign-extends the lane byte.
//    - func3 001 half: SH writes lanes {a1,0}+1..{a1,0}; LH sign-extends the half.
//    - func3 010 word: SW/LW full word.
//    - func3 100 LBU / 101 LHU: zero-extend. Illegal for stores.
//  - Errors set rsp_err=1 and rsp_rdata=0, with no array write:
//    - half with addr[0]=1, or word with addr[1:0]!=0;
//    - addr[31:2] >= DEPTH_WORDS;
//    - func3 in {011,110,111}, or store with 100/101.
//  - Stores: rsp_rdata=0 and rsp_err per decode.
//  - Reset mid-operation (WAIT or RESP): returns to IDLE. A write not yet committed is
//    dropped; a committed write persists.
//  - rsp_ready held high continuously: back-to-back transactions every WAIT_STATES+2 cycles.
// STRUCTURE
//  - Shared package riscv_pkg:
//    - func3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
//    - typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t.
//  - Sub-module mem_byte_lane (combinational): func3+addr[1:0]+wdata
//    -> byte_en[3:0], shifted wdata, misalign flag. Also raw word -> extended rdata.
//  - Top level holds FSM, counter, request latch and storage array (inferred RAM).
// TESTING
//  1. WAIT_STATES=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> 0xDEADBEEF,
//     rsp_valid exactly 3 cycles after accept.
//  2. SB 0x80 @0x13 over word 0x00000000; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080;
//     LW @0x10 -> 0x80000000.
//  3. LH @0x11 -> rsp_err=1, rdata=0; SW @0x12 -> rsp_err=1 and word 0x10 unchanged.
//  4. LW @ DEPTH_WORDS*4 -> rsp_err=1; store with func3=100 -> rsp_err=1, no write.
//  5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0,
//     second req_valid ignored.
//  6. Assert reset during WAIT of SW 0x12345678 @0x20 -> after release word 0x20 holds
//     its old value, state IDLE, all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder.
//   F3_*        : load/store func3 encodings (size and signedness)
//   mem_state_t : responder FSM states
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } mem_state_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane steering for one load/store access.
//   i_func3   : access size/sign
//   i_lane    : byte address bits [1:0]
//   i_we      : 1 = store
//   i_wdata   : LSB-aligned store data
//   i_raw     : full 32-bit word read from storage
//   o_byte_en : per-byte write enables
//   o_wdata   : store data replicated onto every lane
//   o_err     : misaligned access or illegal func3 for this direction
//   o_rdata   : load data, sign- or zero-extended
module mem_byte_lane
    import riscv_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_lane,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raw,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic        o_err,
    output logic [31:0] o_rdata
);

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_lane, 3'b000} +: 8];
    assign w_half = i_raw[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_byte_en = 4'b0000;
        o_wdata   = i_wdata;
        o_err     = 1'b0;
        o_rdata   = 32'h0;
        case (i_func3)
            F3_B: begin
                o_byte_en = 4'b0001 << i_lane;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = sext8(w_byte);
            end
            F3_H: begin
                o_byte_en = 4'b0011 << {i_lane[1], 1'b0};
                o_wdata   = {2{i_wdata[15:0]}};
                o_rdata   = sext16(w_half);
                o_err     = i_lane[0];
            end
            F3_W: begin
                o_byte_en = 4'b1111;
                o_rdata   = i_raw;
                o_err     = (i_lane != 2'b00);
            end
            // Unsigned variants only exist as loads.
            F3_BU: begin
                o_rdata = {24'h0, w_byte};
                o_err   = i_we;
            end
            F3_HU: begin
                o_rdata = {16'h0, w_half};
                o_err   = i_we | i_lane[0];
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core load/store port: one request at a time over
// valid/ready, fixed wait states, then a held response.
//   clk/reset              : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake
//   req_we/addr/wdata/func3: request fields (byte address, LSB-aligned data)
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata/rsp_err      : extended load data (0 for stores/errors), error flag
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Wraps to 4'hF when WAIT_STATES is 0; the WAIT state is then never entered.
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    mem_state_t  r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_func3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept, w_enter_resp;
    logic        w_src_we;
    logic [31:0] w_src_addr, w_src_wdata;
    logic [2:0]  w_src_func3;
    logic [AW-1:0] w_idx;
    logic        w_oor, w_lane_err, w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh, w_rdata_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MEM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        // Gated by reset so the port refuses requests while reset is held.
        req_ready  = (r_state == MEM_IDLE) && reset;
        rsp_valid  = (r_state == MEM_RESP);
        case (r_state)
            MEM_IDLE: begin
                if (req_valid && req_ready) begin
                    w_cnt_next = 4'd0;
                    w_next     = (WAIT_STATES == 0) ? MEM_RESP : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (r_cnt == WS_LAST) w_next = MEM_RESP;
                else                  w_cnt_next = r_cnt + 4'd1;
            end
            MEM_RESP: begin
                if (rsp_ready) w_next = MEM_IDLE;
            end
            default: w_next = MEM_IDLE;
        endcase
    end

    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (w_next == MEM_RESP) && (r_state != MEM_RESP);

    // With zero wait states the commit happens on the accept edge itself,
    // before the latch holds anything, so take the fields from the port.
    assign w_src_we    = (r_state == MEM_IDLE) ? req_we    : r_we;
    assign w_src_addr  = (r_state == MEM_IDLE) ? req_addr  : r_addr;
    assign w_src_wdata = (r_state == MEM_IDLE) ? req_wdata : r_wdata;
    assign w_src_func3 = (r_state == MEM_IDLE) ? req_func3 : r_func3;

    assign w_idx = w_src_addr[AW+1:2];
    assign w_oor = |w_src_addr[31:AW+2];
    assign w_err = w_lane_err | w_oor;

    mem_byte_lane u_lane (
        .i_func3   (w_src_func3),
        .i_lane    (w_src_addr[1:0]),
        .i_we      (w_src_we),
        .i_wdata   (w_src_wdata),
        .i_raw     (r_mem[w_idx]),
        .o_byte_en (w_be),
        .o_wdata   (w_wdata_sh),
        .o_err     (w_lane_err),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_func3 <= req_func3;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_src_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_src_we || w_err) ? 32'h0 : w_rdata_ext;
        end else if ((r_state == MEM_RESP) && rsp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int passed = 0;
    int total  = 0;

    logic [7:0] mbytes [DEPTH*4];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_func3 (req_func3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-addressed little-endian memory with size/sign rules.
    function automatic void model_txn(input bit we, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [2:0] f3,
                                      output logic [31:0] rd, output bit err);
        int size;
        bit uns;
        bit legal;
        logic [31:0] v;
        legal = 1'b1;
        uns   = 1'b0;
        size  = 4;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; end
            3'd5: begin size = 2; uns = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (we && uns) legal = 1'b0;
        err = !legal || ((addr % size) != 0) || ((addr / 4) >= DEPTH);
        rd  = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mbytes[addr + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[addr + i];
            if (!uns && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
        int guard;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_func3 = f3;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 40) begin
            step();
            guard++;
        end
        check("req_ready_seen", {31'h0, req_ready}, 32'h1);
        step();
        req_valid = 1'b0;
    endtask

    // Returns in the first cycle rsp_valid is seen; lat counts cycles from accept cycle.
    task automatic wait_rsp(output logic [31:0] rd, output logic err, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic do_txn(input string tag, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output logic err);
        logic [31:0] erd;
        bit eerr;
        int lat;
        issue(we, addr, wd, f3);
        wait_rsp(rd, err, lat);
        step();
        model_txn(we, addr, wd, f3, erd, eerr);
        check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_err"}, {31'h0, err}, {31'h0, eerr});
    endtask

    logic [31:0] rd, hold_rd, a;
    logic        er;
    logic [2:0]  f3;
    bit          we;
    int          lat;
    logic [2:0]  f3_tab [8];

    initial begin
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
        rsp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'h0, rsp_err}, 32'h0);
        reset = 1'b1;
        step();
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);

        // Known contents for words 0..15.
        for (int w = 0; w < 16; w++) do_txn("fill", 1'b1, 32'(w * 4), $urandom, 3'd2, rd, er);

        // 1: word store/load
        do_txn("t1_sw", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, er);
        check("t1_sw_err", {31'h0, er}, 32'h0);
        issue(1'b0, 32'h10, 32'h0, 3'd2);
        wait_rsp(rd, er, lat);
        step();
        check("t1_lw_lat", 32'(lat), 32'd3);
        check("t1_lw", rd, 32'hDEADBEEF);

        // 2: byte store into zeroed word, signed/unsigned byte loads
        do_txn("t2_sw0", 1'b1, 32'h10, 32'h0, 3'd2, rd, er);
        do_txn("t2_sb", 1'b1, 32'h13, 32'h80, 3'd0, rd, er);
        do_txn("t2_lb", 1'b0, 32'h13, 32'h0, 3'd0, rd, er);
        check("t2_lb_val", rd, 32'hFFFFFF80);
        do_txn("t2_lbu", 1'b0, 32'h13, 32'h0, 3'd4, rd, er);
        check("t2_lbu_val", rd, 32'h00000080);
        do_txn("t2_lw", 1'b0, 32'h10, 32'h0, 3'd2, rd, er);
        check("t2_lw_val", rd, 32'h80000000);

        // 3: misalignment
        do_txn("t3_lh", 1'b0, 32'h11, 32'h0, 3'd1, rd, er);
        check("t3_lh_err", {31'h0, er}, 32'h1);
        check("t3_lh_rd", rd, 32'h0);
        do_txn("t3_sw", 1'b1, 32'h12, 32'hCAFEF00D, 3'd2, rd, er);
        check("t3_sw_err", {31'h0, er}, 32'h1);
        do_txn("t3_lw", 1'b0, 32'h10, 32'h0, 3'd2, rd, er);
        check("t3_lw_val", rd, 32'h80000000);

        // 4: out of range, store with unsigned func3
        do_txn("t4_oor", 1'b0, 32'(DEPTH * 4), 32'h0, 3'd2, rd, er);
        check("t4_oor_err", {31'h0, er}, 32'h1);
        do_txn("t4_sbu", 1'b1, 32'h10, 32'h55, 3'd4, rd, er);
        check("t4_sbu_err", {31'h0, er}, 32'h1);
        do_txn("t4_lw", 1'b0, 32'h10, 32'h0, 3'd2, rd, er);
        check("t4_lw_val", rd, 32'h80000000);

        // 5: response back-pressure, competing request ignored
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 3'd2);
        wait_rsp(hold_rd, er, lat);
        check("t5_first", hold_rd, 32'h80000000);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_func3 = 3'd2;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_valid", {31'h0, rsp_valid}, 32'h1);
            check("t5_rdata", rsp_rdata, hold_rd);
            check("t5_req_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("t5_released", {31'h0, rsp_valid}, 32'h0);
        do_txn("t5_lw", 1'b0, 32'h10, 32'h0, 3'd2, rd, er);
        check("t5_lw_val", rd, 32'h80000000);

        // 6: reset during WAIT drops the uncommitted store
        do_txn("t6_old", 1'b1, 32'h20, 32'hA5A5A5A5, 3'd2, rd, er);
        issue(1'b1, 32'h20, 32'h12345678, 3'd2);
        reset = 1'b0;
        #1;
        check("t6_rst_ready", {31'h0, req_ready}, 32'h0);
        check("t6_rst_valid", {31'h0, rsp_valid}, 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("t6_idle_ready", {31'h0, req_ready}, 32'h1);
        check("t6_idle_valid", {31'h0, rsp_valid}, 32'h0);
        check("t6_idle_rdata", rsp_rdata, 32'h0);
        check("t6_idle_err", {31'h0, rsp_err}, 32'h0);
        step();
        do_txn("t6_lw", 1'b0, 32'h20, 32'h0, 3'd2, rd, er);
        check("t6_lw_val", rd, 32'hA5A5A5A5);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, 63));
            do_txn("rnd", we, a, $urandom, f3, rd, er);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
